// File: rtl/id_pipe.sv
// RV32I decode stage: combinational decode of the fetched word, captured into a
// two-entry (head + skid) buffer so that the ready returned to fetch is a register.
module id_pipe #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  CLK,
  input  logic                  RSTn,
  input  logic                  FLUSH,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic [31:0]           IN_INSTR,
  input  logic [XLEN-1:0]       IN_PC,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [REG_ADDR_W-1:0] RF_RA1,
  output logic [REG_ADDR_W-1:0] RF_RA2,
  output logic [REG_ADDR_W-1:0] RF_WA1,
  output logic [XLEN-1:0]       IMM,
  output logic [XLEN-1:0]       OUT_PC,
  output logic [3:0]            OP_CLASS,
  output logic                  ILLEGAL
);

  localparam int unsigned NREGS = 2 ** REG_ADDR_W;

  typedef struct packed {
    logic                  illegal;
    logic [3:0]            op_class;
    logic [REG_ADDR_W-1:0] ra1;
    logic [REG_ADDR_W-1:0] ra2;
    logic [REG_ADDR_W-1:0] wa1;
    logic [XLEN-1:0]       imm;
    logic [XLEN-1:0]       pc;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;

  state_e state_q, state_d;
  entry_t head_q, head_d, skid_q, skid_d;
  logic   in_ready_q, in_ready_d;
  logic   out_valid_q, out_valid_d;
  entry_t dec;

  logic [4:0]  rs1, rs2, rd;
  logic [31:0] imm32;
  logic [3:0]  cls;
  logic        known, use_rs1, use_rs2, use_rd, bad;

  // Decode of the incoming word; an illegal word keeps only its PC.
  always_comb begin
    rs1     = IN_INSTR[19:15];
    rs2     = IN_INSTR[24:20];
    rd      = IN_INSTR[11:7];
    imm32   = 32'd0;
    cls     = 4'd15;
    known   = 1'b1;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    use_rd  = 1'b0;
    case (IN_INSTR[6:0])
      7'b0110011: begin cls = 4'd0; use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1; end
      7'b0010011, 7'b0000011, 7'b1100111: begin
        cls     = (IN_INSTR[6:0] == 7'b0010011) ? 4'd1 :
                  (IN_INSTR[6:0] == 7'b0000011) ? 4'd2 : 4'd6;
        use_rs1 = 1'b1;
        use_rd  = 1'b1;
        imm32   = {{20{IN_INSTR[31]}}, IN_INSTR[31:20]};
      end
      7'b0100011: begin
        cls     = 4'd3;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        imm32   = {{20{IN_INSTR[31]}}, IN_INSTR[31:25], IN_INSTR[11:7]};
      end
      7'b1100011: begin
        cls     = 4'd4;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        imm32   = {{19{IN_INSTR[31]}}, IN_INSTR[31], IN_INSTR[7], IN_INSTR[30:25],
                   IN_INSTR[11:8], 1'b0};
      end
      7'b1101111: begin
        cls    = 4'd5;
        use_rd = 1'b1;
        imm32  = {{11{IN_INSTR[31]}}, IN_INSTR[31], IN_INSTR[19:12], IN_INSTR[20],
                  IN_INSTR[30:21], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        cls    = (IN_INSTR[6:0] == 7'b0110111) ? 4'd7 : 4'd8;
        use_rd = 1'b1;
        imm32  = {IN_INSTR[31:12], 12'd0};
      end
      default: known = 1'b0;
    endcase

    bad = (IN_INSTR[1:0] != 2'b11) || !known
          || (use_rs1 && (32'(rs1) >= NREGS))
          || (use_rs2 && (32'(rs2) >= NREGS))
          || (use_rd  && (32'(rd)  >= NREGS));

    dec    = '0;
    dec.pc = IN_PC;
    if (bad) begin
      dec.illegal  = 1'b1;
      dec.op_class = 4'd15;
    end else begin
      dec.op_class = cls;
      dec.ra1      = use_rs1 ? REG_ADDR_W'(rs1) : '0;
      dec.ra2      = use_rs2 ? REG_ADDR_W'(rs2) : '0;
      dec.wa1      = use_rd  ? REG_ADDR_W'(rd)  : '0;
      dec.imm      = XLEN'($signed(imm32));
    end
  end

  // Buffer control: head/skid occupancy with flush overriding any transfer.
  always_comb begin
    logic acc, rel;
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    acc     = IN_VALID && in_ready_q;
    rel     = (state_q != EMPTY) && OUT_READY;
    case (state_q)
      EMPTY: if (acc) begin state_d = ONE; head_d = dec; end
      ONE: begin
        if (acc && rel)       head_d = dec;
        else if (acc)         begin state_d = FULL; skid_d = dec; end
        else if (rel)         state_d = EMPTY;
      end
      FULL: if (rel) begin state_d = ONE; head_d = skid_q; end
      default: state_d = EMPTY;
    endcase
    if (FLUSH) state_d = EMPTY;
    in_ready_d  = (state_d != FULL);
    out_valid_d = (state_d != EMPTY);
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q     <= EMPTY;
      head_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign IN_READY  = in_ready_q;
  assign OUT_VALID = out_valid_q;
  assign RF_RA1    = head_q.ra1;
  assign RF_RA2    = head_q.ra2;
  assign RF_WA1    = head_q.wa1;
  assign IMM       = head_q.imm;
  assign OUT_PC    = head_q.pc;
  assign OP_CLASS  = head_q.op_class;
  assign ILLEGAL   = head_q.illegal;

endmodule

// File: tb/tb_id_pipe.sv
// Directed bench for id_pipe: three instances (RV32I, RV32E, XLEN=64) share one
// stimulus stream; each check targets the instance whose behaviour it exercises.
module tb_id_pipe;

  logic        clk = 1'b0;
  logic        rstn, flush, in_valid, out_ready;
  logic [31:0] instr;
  logic [63:0] pc;

  logic       a_in_ready, a_out_valid, a_illegal;
  logic [4:0] a_ra1, a_ra2, a_wa1;
  logic [31:0] a_imm, a_pc;
  logic [3:0] a_cls;

  logic       b_in_ready, b_out_valid, b_illegal;
  logic [3:0] b_ra1, b_ra2, b_wa1;
  logic [31:0] b_imm, b_pc;
  logic [3:0] b_cls;

  logic       c_in_ready, c_out_valid, c_illegal;
  logic [4:0] c_ra1, c_ra2, c_wa1;
  logic [63:0] c_imm, c_pc;
  logic [3:0] c_cls;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_pipe #(.XLEN(32), .REG_ADDR_W(5)) u_a (
    .CLK(clk), .RSTn(rstn), .FLUSH(flush), .IN_VALID(in_valid), .IN_READY(a_in_ready),
    .IN_INSTR(instr), .IN_PC(pc[31:0]), .OUT_VALID(a_out_valid), .OUT_READY(out_ready),
    .RF_RA1(a_ra1), .RF_RA2(a_ra2), .RF_WA1(a_wa1), .IMM(a_imm), .OUT_PC(a_pc),
    .OP_CLASS(a_cls), .ILLEGAL(a_illegal));

  id_pipe #(.XLEN(32), .REG_ADDR_W(4)) u_b (
    .CLK(clk), .RSTn(rstn), .FLUSH(flush), .IN_VALID(in_valid), .IN_READY(b_in_ready),
    .IN_INSTR(instr), .IN_PC(pc[31:0]), .OUT_VALID(b_out_valid), .OUT_READY(out_ready),
    .RF_RA1(b_ra1), .RF_RA2(b_ra2), .RF_WA1(b_wa1), .IMM(b_imm), .OUT_PC(b_pc),
    .OP_CLASS(b_cls), .ILLEGAL(b_illegal));

  id_pipe #(.XLEN(64), .REG_ADDR_W(5)) u_c (
    .CLK(clk), .RSTn(rstn), .FLUSH(flush), .IN_VALID(in_valid), .IN_READY(c_in_ready),
    .IN_INSTR(instr), .IN_PC(pc), .OUT_VALID(c_out_valid), .OUT_READY(out_ready),
    .RF_RA1(c_ra1), .RF_RA2(c_ra2), .RF_WA1(c_wa1), .IMM(c_imm), .OUT_PC(c_pc),
    .OP_CLASS(c_cls), .ILLEGAL(c_illegal));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] w, input logic [63:0] p);
    instr    = w;
    pc       = p;
    in_valid = 1'b1;
  endtask

  // Stream table: word, pc, class, ra1, ra2, wa1, imm
  logic [31:0] s_w   [4] = '{32'h008000EF, 32'hFE208EE3, 32'h0020A423, 32'h123452B7};
  logic [3:0]  s_cls [4] = '{4'd5, 4'd4, 4'd3, 4'd7};
  logic [4:0]  s_ra1 [4] = '{5'd0, 5'd1, 5'd1, 5'd0};
  logic [4:0]  s_ra2 [4] = '{5'd0, 5'd2, 5'd2, 5'd0};
  logic [4:0]  s_wa1 [4] = '{5'd1, 5'd0, 5'd0, 5'd5};
  logic [31:0] s_imm [4] = '{32'h8, 32'hFFFFFFFC, 32'h8, 32'h12345000};

  initial begin
    rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    instr = 32'd0; pc = 64'd0;
    #12;
    check("rst_valid", 64'(a_out_valid), 64'd0);
    check("rst_ready", 64'(a_in_ready), 64'd1);
    check("rst_ra1",   64'(a_ra1), 64'd0);
    check("rst_wa1",   64'(a_wa1), 64'd0);
    check("rst_imm",   64'(a_imm), 64'd0);
    check("rst_pc",    64'(a_pc), 64'd0);
    check("rst_cls",   64'(a_cls), 64'd0);
    check("rst_ill",   64'(a_illegal), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    step();

    // Single ADDI x1,x2,-1
    out_ready = 1'b1;
    drive(32'hFFF10093, 64'h100);
    step();
    in_valid = 1'b0;
    check("addi_valid", 64'(a_out_valid), 64'd1);
    check("addi_ra1",   64'(a_ra1), 64'd2);
    check("addi_ra2",   64'(a_ra2), 64'd0);
    check("addi_wa1",   64'(a_wa1), 64'd1);
    check("addi_imm",   64'(a_imm), 64'hFFFFFFFF);
    check("addi_cls",   64'(a_cls), 64'd1);
    check("addi_pc",    64'(a_pc), 64'h100);
    check("addi_imm64", c_imm, 64'hFFFFFFFFFFFFFFFF);
    step();
    check("addi_drained", 64'(a_out_valid), 64'd0);

    // Back-to-back stream at full throughput
    for (int i = 0; i < 4; i++) begin
      drive(s_w[i], 64'h200 + 64'(4 * i));
      step();
      check($sformatf("strm%0d_valid", i), 64'(a_out_valid), 64'd1);
      check($sformatf("strm%0d_ready", i), 64'(a_in_ready), 64'd1);
      check($sformatf("strm%0d_cls", i), 64'(a_cls), 64'(s_cls[i]));
      check($sformatf("strm%0d_ra1", i), 64'(a_ra1), 64'(s_ra1[i]));
      check($sformatf("strm%0d_ra2", i), 64'(a_ra2), 64'(s_ra2[i]));
      check($sformatf("strm%0d_wa1", i), 64'(a_wa1), 64'(s_wa1[i]));
      check($sformatf("strm%0d_imm", i), 64'(a_imm), 64'(s_imm[i]));
      check($sformatf("strm%0d_pc", i), 64'(a_pc), 64'h200 + 64'(4 * i));
    end
    in_valid = 1'b0;
    step();
    check("strm_empty", 64'(a_out_valid), 64'd0);

    // Back-pressure: two accepted, third waits until the skid drains
    out_ready = 1'b0;
    drive(32'h00100093, 64'h400);
    step();
    check("bp1_ready", 64'(a_in_ready), 64'd1);
    check("bp1_wa1",   64'(a_wa1), 64'd1);
    drive(32'h00200113, 64'h404);
    step();
    check("bp2_ready", 64'(a_in_ready), 64'd0);
    check("bp2_wa1",   64'(a_wa1), 64'd1);
    drive(32'h00300193, 64'h408);
    step();
    check("bp3_ready", 64'(a_in_ready), 64'd0);
    check("bp3_hold_wa1", 64'(a_wa1), 64'd1);
    check("bp3_hold_imm", 64'(a_imm), 64'd1);
    out_ready = 1'b1;
    step();
    check("bp4_ready", 64'(a_in_ready), 64'd1);
    check("bp4_wa1",   64'(a_wa1), 64'd2);
    check("bp4_pc",    64'(a_pc), 64'h404);
    step();
    in_valid = 1'b0;
    check("bp5_wa1",   64'(a_wa1), 64'd3);
    check("bp5_imm",   64'(a_imm), 64'd3);
    step();
    check("bp6_empty", 64'(a_out_valid), 64'd0);

    // Flush from FULL with a concurrent offer, then from ONE over an accept
    out_ready = 1'b0;
    drive(32'h00100093, 64'h500);
    step();
    drive(32'h00200113, 64'h504);
    step();
    check("fl_full", 64'(a_in_ready), 64'd0);
    drive(32'h00300193, 64'h508);
    flush = 1'b1;
    step();
    check("fl_valid", 64'(a_out_valid), 64'd0);
    check("fl_ready", 64'(a_in_ready), 64'd1);
    flush = 1'b0;
    drive(32'h00100093, 64'h50C);
    step();
    drive(32'h00300193, 64'h510);
    flush = 1'b1;
    out_ready = 1'b1;
    step();
    flush = 1'b0;
    check("fl1_valid", 64'(a_out_valid), 64'd0);
    drive(32'h123452B7, 64'h600);
    step();
    in_valid = 1'b0;
    check("fl_next_wa1", 64'(a_wa1), 64'd5);
    check("fl_next_pc",  64'(a_pc), 64'h600);
    step();
    check("fl_after_empty", 64'(a_out_valid), 64'd0);

    // Illegal words and RV32E register-range limits
    drive(32'h00000000, 64'h300);
    step();
    check("ill0_ill", 64'(a_illegal), 64'd1);
    check("ill0_cls", 64'(a_cls), 64'd15);
    check("ill0_imm", 64'(a_imm), 64'd0);
    check("ill0_wa1", 64'(a_wa1), 64'd0);
    check("ill0_pc",  64'(a_pc), 64'h300);
    drive(32'h01000093, 64'h304);
    step();
    check("e16_ill", 64'(b_illegal), 64'd0);
    check("e16_imm", 64'(b_imm), 64'd16);
    check("e16_wa1", 64'(b_wa1), 64'd1);
    drive(32'h01F00093, 64'h308);
    step();
    check("e31_ill", 64'(b_illegal), 64'd0);
    check("e31_imm", 64'(b_imm), 64'd31);
    drive(32'h00000893, 64'h30C);
    step();
    in_valid = 1'b0;
    check("e17_ill", 64'(b_illegal), 64'd1);
    check("e17_cls", 64'(b_cls), 64'd15);
    check("e17_wa1", 64'(b_wa1), 64'd0);
    check("e17_pc",  64'(b_pc), 64'h30C);
    check("i17_ill", 64'(a_illegal), 64'd0);
    check("i17_wa1", 64'(a_wa1), 64'd17);
    step();

    // Asynchronous reset while FULL, between clock edges
    out_ready = 1'b0;
    drive(32'hFFF10093, 64'h700);
    step();
    drive(32'h123452B7, 64'h704);
    step();
    in_valid = 1'b0;
    check("ar_full", 64'(c_in_ready), 64'd0);
    check("ar_pre_imm", c_imm, 64'hFFFFFFFFFFFFFFFF);
    #2;
    rstn = 1'b0;
    #1;
    check("ar_valid", 64'(c_out_valid), 64'd0);
    check("ar_ready", 64'(c_in_ready), 64'd1);
    check("ar_imm",   c_imm, 64'd0);
    check("ar_pc",    c_pc, 64'd0);
    check("ar_wa1",   64'(c_wa1), 64'd0);
    check("ar_ra1",   64'(c_ra1), 64'd0);
    check("ar_cls",   64'(c_cls), 64'd0);
    check("ar_a_valid", 64'(a_out_valid), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
